// File: rtl/mole_scheduler_pkg.sv
// Shared types and helpers for the mole placement engine.
// Package constants must agree with the parameters passed to mole_scheduler.
package whac_pkg;
    localparam int unsigned NUM_HOLES_DEF  = 18;
    localparam int unsigned MAX_MOLES_DEF  = 4;
    localparam int unsigned LIFETIME_W_DEF = 8;
    localparam int unsigned HOLE_W         = $clog2(NUM_HOLES_DEF);
    localparam int unsigned CNT_W          = $clog2(MAX_MOLES_DEF + 1);

    typedef logic [HOLE_W-1:0]         hole_idx_t;
    typedef logic [CNT_W-1:0]          cnt_t;
    typedef logic [LIFETIME_W_DEF-1:0] life_t;

    typedef struct packed {
        logic      valid;
        hole_idx_t hole;
        life_t     timer;
    } slot_t;

    function automatic cnt_t popcount(input logic [MAX_MOLES_DEF-1:0] v);
        cnt_t c;
        c = '0;
        for (int unsigned i = 0; i < MAX_MOLES_DEF; i++) begin
            c = c + cnt_t'(v[i]);
        end
        return c;
    endfunction
endpackage

// File: rtl/mole_scheduler_if.sv
// Bundle between the level controller / hole I/O and the mole scheduler.
interface mole_scheduler_if;
    import whac_pkg::*;

    logic                     enable;
    logic                     spawn_clk;
    cnt_t                     active_moles;
    life_t                    lifetime;
    logic [NUM_HOLES_DEF-1:0] hit_mask;
    logic [NUM_HOLES_DEF-1:0] mole_positions;
    cnt_t                     live_count;
    cnt_t                     hit_count;
    cnt_t                     miss_count;

    modport master (
        output enable, spawn_clk, active_moles, lifetime, hit_mask,
        input  mole_positions, live_count, hit_count, miss_count
    );

    modport slave (
        input  enable, spawn_clk, active_moles, lifetime, hit_mask,
        output mole_positions, live_count, hit_count, miss_count
    );
endinterface

// File: rtl/mole_scheduler_slot.sv
// One mole slot: holds a hole index and its lifetime countdown.
module mole_slot
    import whac_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      clear,
    input  logic      tick,
    input  logic      load,
    input  logic      remove,
    input  hole_idx_t load_hole,
    input  life_t     load_timer,
    output logic      occupied,
    output hole_idx_t hole,
    output logic      expire_now
);
    slot_t s;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            s <= '0;
        end else if (load) begin
            s <= '{valid: 1'b1, hole: load_hole, timer: load_timer};
        end else if (tick && s.valid) begin
            if (remove || expire_now) s.valid <= 1'b0;
            else                      s.timer <= s.timer - life_t'(1);
        end
    end

    always_comb begin
        occupied   = s.valid;
        hole       = s.hole;
        expire_now = s.valid && (s.timer == life_t'(1));
    end
endmodule

// File: rtl/rng.sv
// 16-bit Galois LFSR stepping every clock, folded into OFFSET..MAX_VALUE.
module rng #(
    parameter int unsigned OFFSET    = 0,
    parameter int unsigned MAX_VALUE = 17,
    parameter int unsigned SEED      = 123
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic [$clog2(MAX_VALUE+1)-1:0] value
);
    localparam int unsigned VAL_W = $clog2(MAX_VALUE + 1);
    localparam int unsigned RANGE = MAX_VALUE - OFFSET + 1;

    logic [15:0] state;

    always_ff @(posedge clk) begin
        if (reset) state <= 16'(SEED);
        else       state <= {1'b0, state[15:1]} ^ ({16{state[0]}} & 16'hB400);
    end

    always_comb begin
        value = VAL_W'(OFFSET + (32'(state) % RANGE));
    end
endmodule

// File: rtl/mole_scheduler.sv
// Mole placement engine: slot pool, unique-hole spawning with linear probe,
// hit/expiry removal and per-cycle hit/miss count pulses.
module mole_scheduler
    import whac_pkg::*;
#(
    parameter int unsigned NUMBER_OF_HOLES = NUM_HOLES_DEF,
    parameter int unsigned MAX_MOLES       = MAX_MOLES_DEF,
    parameter int unsigned LIFETIME_W      = LIFETIME_W_DEF,
    parameter int unsigned SEED            = 123
) (
    input  logic             clk,
    input  logic             reset,
    mole_scheduler_if.slave  bus
);
    logic                       prev_spawn;
    logic                       spawn_edge;
    logic                       spawn;
    hole_idx_t                  r;
    hole_idx_t                  target;
    logic                       hole_found;
    logic                       slot_found;
    life_t                      load_timer;
    cnt_t                       cap;
    logic [MAX_MOLES-1:0]       occ, expire, hit_v, miss_v, sel_oh, load_v, next_valid;
    hole_idx_t                  slot_hole [MAX_MOLES];
    logic [NUMBER_OF_HOLES-1:0] next_pos;

    rng #(.OFFSET(0), .MAX_VALUE(NUMBER_OF_HOLES - 1), .SEED(SEED)) u_rng (
        .clk   (clk),
        .reset (reset),
        .value (r)
    );

    for (genvar g = 0; g < MAX_MOLES; g++) begin : g_slot
        mole_slot u_slot (
            .clk        (clk),
            .reset      (reset),
            .clear      (~bus.enable),
            .tick       (bus.enable),
            .load       (load_v[g]),
            .remove     (hit_v[g]),
            .load_hole  (target),
            .load_timer (load_timer),
            .occupied   (occ[g]),
            .hole       (slot_hole[g]),
            .expire_now (expire[g])
        );
    end

    always_comb begin
        spawn_edge = bus.spawn_clk & ~prev_spawn;
        cap        = (bus.active_moles > cnt_t'(MAX_MOLES)) ? cnt_t'(MAX_MOLES) : bus.active_moles;
        load_timer = (bus.lifetime == '0) ? life_t'(1) : bus.lifetime;

        // Probe from r upward with wrap, against the registered occupancy.
        hole_found = 1'b0;
        target     = '0;
        for (int unsigned d = 0; d < NUMBER_OF_HOLES; d++) begin
            int unsigned t;
            t = 32'(r) + d;
            if (t >= NUMBER_OF_HOLES) t = t - NUMBER_OF_HOLES;
            if (!hole_found && !bus.mole_positions[hole_idx_t'(t)]) begin
                hole_found = 1'b1;
                target     = hole_idx_t'(t);
            end
        end

        slot_found = 1'b0;
        sel_oh     = '0;
        for (int unsigned i = 0; i < MAX_MOLES; i++) begin
            if (!occ[i] && !slot_found) begin
                slot_found = 1'b1;
                sel_oh[i]  = 1'b1;
            end
        end

        spawn  = bus.enable & spawn_edge & (bus.live_count < cap) & hole_found & slot_found;
        load_v = spawn ? sel_oh : '0;

        // Hit beats expiry in the same cycle; disabled cycles remove silently.
        next_pos   = '0;
        next_valid = '0;
        hit_v      = '0;
        miss_v     = '0;
        for (int unsigned i = 0; i < MAX_MOLES; i++) begin
            hit_v[i]  = bus.enable & occ[i] & bus.hit_mask[slot_hole[i]];
            miss_v[i] = bus.enable & expire[i] & ~hit_v[i];
            if (bus.enable && occ[i] && !hit_v[i] && !expire[i]) begin
                next_valid[i]           = 1'b1;
                next_pos[slot_hole[i]]  = 1'b1;
            end
            if (load_v[i]) begin
                next_valid[i]    = 1'b1;
                next_pos[target] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_spawn         <= 1'b0;
            bus.mole_positions <= '0;
            bus.live_count     <= '0;
            bus.hit_count      <= '0;
            bus.miss_count     <= '0;
        end else begin
            prev_spawn         <= bus.spawn_clk;
            bus.mole_positions <= next_pos;
            bus.live_count     <= popcount(next_valid);
            bus.hit_count      <= popcount(hit_v);
            bus.miss_count     <= popcount(miss_v);
        end
    end
endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler: a cycle model pushes expected outputs
// before each edge, which are popped and compared after it.
module tb_mole_scheduler;
    import whac_pkg::*;

    localparam int unsigned H = 18;
    localparam int unsigned M = 4;

    logic clk = 1'b0;
    logic reset;

    mole_scheduler_if bus ();

    mole_scheduler #(
        .NUMBER_OF_HOLES (18),
        .MAX_MOLES       (4),
        .LIFETIME_W      (8),
        .SEED            (123)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [H-1:0] pos;
        logic [2:0]   live;
        logic [2:0]   hit;
        logic [2:0]   miss;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic         m_valid [M];
    logic [4:0]   m_hole  [M];
    logic [7:0]   m_timer [M];
    logic         m_prev;
    logic [H-1:0] m_pos;
    logic [15:0]  m_lfsr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_edge(output exp_t e);
        int unsigned r, cap, live_pre, hs, ss, t;
        logic        hfound, sfound, edge_det;
        e = '0;
        if (reset) begin
            for (int i = 0; i < M; i++) m_valid[i] = 1'b0;
            m_prev = 1'b0;
            m_lfsr = 16'd123;
        end else begin
            r        = 32'(m_lfsr) % H;
            m_lfsr   = lfsr_next(m_lfsr);
            edge_det = bus.spawn_clk && !m_prev;
            m_prev   = bus.spawn_clk;
            if (!bus.enable) begin
                for (int i = 0; i < M; i++) m_valid[i] = 1'b0;
            end else begin
                cap      = (32'(bus.active_moles) > M) ? M : 32'(bus.active_moles);
                live_pre = 0;
                for (int i = 0; i < M; i++) if (m_valid[i]) live_pre++;
                hfound = 1'b0; hs = 0;
                for (int unsigned d = 0; d < H; d++) begin
                    t = (r + d) % H;
                    if (!hfound && !m_pos[t]) begin hfound = 1'b1; hs = t; end
                end
                sfound = 1'b0; ss = 0;
                for (int i = 0; i < M; i++) begin
                    if (!sfound && !m_valid[i]) begin sfound = 1'b1; ss = i; end
                end
                for (int i = 0; i < M; i++) begin
                    if (m_valid[i]) begin
                        if (bus.hit_mask[m_hole[i]]) begin
                            m_valid[i] = 1'b0; e.hit = e.hit + 3'd1;
                        end else if (m_timer[i] == 8'd1) begin
                            m_valid[i] = 1'b0; e.miss = e.miss + 3'd1;
                        end else begin
                            m_timer[i] = m_timer[i] - 8'd1;
                        end
                    end
                end
                if (edge_det && live_pre < cap && hfound && sfound) begin
                    m_valid[ss] = 1'b1;
                    m_hole[ss]  = 5'(hs);
                    m_timer[ss] = (bus.lifetime == 8'd0) ? 8'd1 : bus.lifetime;
                end
            end
        end
        m_pos = '0;
        for (int i = 0; i < M; i++) begin
            if (m_valid[i]) begin
                m_pos[m_hole[i]] = 1'b1;
                e.live = e.live + 3'd1;
            end
        end
        e.pos = m_pos;
    endtask

    task automatic step();
        exp_t e;
        model_edge(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_pos",  32'(bus.mole_positions), 32'(e.pos));
        check("sb_live", 32'(bus.live_count),     32'(e.live));
        check("sb_hit",  32'(bus.hit_count),      32'(e.hit));
        check("sb_miss", 32'(bus.miss_count),     32'(e.miss));
    endtask

    task automatic spawn_pulse();
        bus.spawn_clk = 1'b1; step();
        bus.spawn_clk = 1'b0; step();
    endtask

    task automatic wait_r17(input string tag);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            if ((32'(m_lfsr) % H) == 17) found = 1'b1;
            else step();
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        int sum_pos, sum_miss, peak;
        reset            = 1'b1;
        bus.enable       = 1'b0;
        bus.spawn_clk    = 1'b0;
        bus.active_moles = '0;
        bus.lifetime     = '0;
        bus.hit_mask     = '0;
        m_prev = 1'b0; m_pos = '0; m_lfsr = 16'd0;
        for (int i = 0; i < M; i++) begin
            m_valid[i] = 1'b0; m_hole[i] = '0; m_timer[i] = '0;
        end

        repeat (3) step();
        check("rst_pos",  32'(bus.mole_positions), 32'd0);
        check("rst_live", 32'(bus.live_count),     32'd0);
        check("rst_hit",  32'(bus.hit_count),      32'd0);
        check("rst_miss", 32'(bus.miss_count),     32'd0);
        reset = 1'b0;
        step();

        // Cap of two live moles, lifetime 5.
        bus.enable = 1'b1; bus.active_moles = 3'd2; bus.lifetime = 8'd5;
        sum_pos = 0; sum_miss = 0; peak = 0;
        for (int k = 0; k < 8; k++) begin
            bus.spawn_clk = (k < 6) && (k % 2 == 0);
            step();
            sum_pos  += $countones(bus.mole_positions);
            sum_miss += 32'(bus.miss_count);
            if (32'(bus.live_count) > peak) peak = 32'(bus.live_count);
        end
        bus.spawn_clk = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            sum_pos  += $countones(bus.mole_positions);
            sum_miss += 32'(bus.miss_count);
        end
        check("cap_peak",    32'(peak),     32'd2);
        check("cap_visible", 32'(sum_pos),  32'd10);
        check("cap_misses",  32'(sum_miss), 32'd2);

        // Probe wrap from hole 17.
        bus.active_moles = 3'd4; bus.lifetime = 8'd255;
        wait_r17("probe_wait1"); spawn_pulse();
        check("probe_first", 32'(bus.mole_positions), 32'h20000);
        wait_r17("probe_wait2"); spawn_pulse();
        check("probe_wrap",  32'(bus.mole_positions), 32'h20001);
        wait_r17("probe_wait3"); spawn_pulse();
        check("probe_next",  32'(bus.mole_positions), 32'h20003);
        bus.enable = 1'b0; step();
        check("disable_clear", 32'(bus.live_count), 32'd0);
        bus.enable = 1'b1; step();

        // Hit and expiry in the same cycle.
        bus.lifetime = 8'd1;
        bus.spawn_clk = 1'b1; step(); bus.spawn_clk = 1'b0;
        check("hx_up", 32'($countones(bus.mole_positions)), 32'd1);
        bus.hit_mask = m_pos; step(); bus.hit_mask = '0;
        check("hx_hit",  32'(bus.hit_count),      32'd1);
        check("hx_miss", 32'(bus.miss_count),     32'd0);
        check("hx_pos",  32'(bus.mole_positions), 32'd0);

        // Lifetime 0 behaves as 1.
        bus.lifetime = 8'd0;
        bus.spawn_clk = 1'b1; step(); bus.spawn_clk = 1'b0;
        check("lt0_up", 32'(bus.live_count), 32'd1);
        step();
        check("lt0_miss", 32'(bus.miss_count), 32'd1);

        // Full-mask hits.
        bus.hit_mask = '1; step(); bus.hit_mask = '0;
        check("hit_empty", 32'(bus.hit_count), 32'd0);
        bus.lifetime = 8'd100;
        repeat (3) spawn_pulse();
        check("three_up", 32'(bus.live_count), 32'd3);
        bus.hit_mask = '1; step(); bus.hit_mask = '0;
        check("hit_three",      32'(bus.hit_count),  32'd3);
        check("hit_three_live", 32'(bus.live_count), 32'd0);

        // Reset mid-lifetime.
        bus.lifetime = 8'd10;
        spawn_pulse(); repeat (3) step();
        reset = 1'b1; step();
        check("rst_mid_pos",  32'(bus.mole_positions), 32'd0);
        check("rst_mid_miss", 32'(bus.miss_count),     32'd0);
        reset = 1'b0;
        sum_miss = 0;
        repeat (12) begin step(); sum_miss += 32'(bus.miss_count); end
        check("rst_mid_nomiss", 32'(sum_miss), 32'd0);

        // Enable drop mid-lifetime, then re-enable without a new edge.
        spawn_pulse(); repeat (3) step();
        bus.enable = 1'b0; bus.spawn_clk = 1'b1; step();
        check("en_drop_pos",  32'(bus.mole_positions), 32'd0);
        check("en_drop_miss", 32'(bus.miss_count),     32'd0);
        step();
        bus.enable = 1'b1; step(); step();
        check("no_phantom", 32'(bus.live_count), 32'd0);
        bus.spawn_clk = 1'b0; step();
        bus.spawn_clk = 1'b1; step();
        check("new_edge", 32'(bus.live_count), 32'd1);
        bus.spawn_clk = 1'b0; step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
